// File: rtl/count_pulse_gen.sv
// Push-button front end for the 4-bit up counter: synchronizes and debounces
// btn_in, then emits single-cycle count pulses with optional auto-repeat.
module count_pulse_gen #(
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic clk,
  input  logic Reset,
  input  logic btn_in,
  input  logic en,
  output logic pulse_out,
  output logic held
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);
  localparam logic [15:0] RD_LAST = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] RP_LAST = 16'(REPEAT_PERIOD - 1);

  logic        sync_p0;
  logic        btn_s;
  state_t      state;
  logic [15:0] db_tmr;
  logic [15:0] rep_tmr;
  logic        rep_first;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sync_p0   <= 1'b0;
      btn_s     <= 1'b0;
      state     <= IDLE;
      db_tmr    <= '0;
      rep_tmr   <= '0;
      rep_first <= 1'b1;
      pulse_out <= 1'b0;
      held      <= 1'b0;
    end else begin
      // synchronizer stage boundary: btn_in -> sync_p0 -> btn_s
      sync_p0   <= btn_in;
      btn_s     <= sync_p0;
      pulse_out <= 1'b0;
      case (state)
        IDLE: begin
          held <= 1'b0;
          if (btn_s) begin
            state  <= PRESS_DB;
            db_tmr <= '0;
          end
        end
        PRESS_DB: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (db_tmr == DB_LAST) begin
            state     <= HELD;
            rep_tmr   <= '0;
            rep_first <= 1'b1;
            held      <= 1'b1;
            pulse_out <= en;
          end else begin
            db_tmr <= db_tmr + 16'd1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state  <= REL_DB;
            db_tmr <= '0;
          end else if (REPEAT_PERIOD != 0) begin
            // First interval is REPEAT_DELAY, then REPEAT_PERIOD; the timer reloads each pulse.
            if (rep_tmr == (rep_first ? RD_LAST : RP_LAST)) begin
              rep_tmr   <= '0;
              rep_first <= 1'b0;
              pulse_out <= en;
            end else begin
              rep_tmr <= rep_tmr + 16'd1;
            end
          end
        end
        REL_DB: begin
          if (btn_s) begin
            state     <= HELD;
            rep_tmr   <= '0;
            rep_first <= 1'b1;
          end else if (db_tmr == DB_LAST) begin
            state <= IDLE;
            held  <= 1'b0;
          end else begin
            db_tmr <= db_tmr + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_pulse_gen.sv
// Bench for count_pulse_gen: two instances (auto-repeat on and off) checked
// every cycle against a run-length/arrival-time model plus literal pulse maps.
module tb_count_pulse_gen;

  localparam int DB = 4;
  localparam int RD = 10;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic btn_in = 1'b0;
  logic en = 1'b1;
  logic pulse_a, held_a, pulse_b, held_b;

  count_pulse_gen #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(3)) dut_a (
    .clk(clk), .Reset(Reset), .btn_in(btn_in), .en(en), .pulse_out(pulse_a), .held(held_a));
  count_pulse_gen #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(0)) dut_b (
    .clk(clk), .Reset(Reset), .btn_in(btn_in), .en(en), .pulse_out(pulse_b), .held(held_b));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model state: two-sample input delay, then per-instance run-length debounce
  bit m_s1, m_s2;
  int cyc;
  bit m_acc[2];
  int m_run[2];
  int m_anchor[2];
  int m_rp[2] = '{3, 0};
  bit exp_pulse[2];
  bit exp_held[2];

  logic [63:0] pm_a, pm_b, hm_a;
  int idx;
  bit prev_a, prev_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    bit bs;
    bit ev;
    int age;
    if (Reset) begin
      m_s1 = 0; m_s2 = 0; cyc = 0;
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0; m_run[i] = 0; m_anchor[i] = 0;
        exp_pulse[i] = 0; exp_held[i] = 0;
      end
      return;
    end
    bs = m_s2;
    m_s2 = m_s1;
    m_s1 = btn_in;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      ev = 0;
      if (!m_acc[i]) begin
        if (bs) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_acc[i] = 1; m_run[i] = 0; m_anchor[i] = cyc; ev = 1;
          end
        end else m_run[i] = 0;
      end else begin
        if (!bs) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_acc[i] = 0; m_run[i] = 0;
          end
        end else if (m_run[i] > 0) begin
          m_run[i] = 0; m_anchor[i] = cyc;
        end else begin
          age = cyc - m_anchor[i];
          if (m_rp[i] != 0 && age >= RD && (age - RD) % m_rp[i] == 0) ev = 1;
        end
      end
      exp_pulse[i] = ev && en;
      exp_held[i]  = m_acc[i];
    end
  endtask

  task automatic begin_test();
    idx = 0; pm_a = '0; pm_b = '0; hm_a = '0;
  endtask

  task automatic step(input bit b, input bit e, input bit r);
    @(negedge clk);
    btn_in = b; en = e; Reset = r;
    @(posedge clk);
    model_update();
    #2;
    chk("pulse_a", pulse_a, exp_pulse[0]);
    chk("held_a",  held_a,  exp_held[0]);
    chk("pulse_b", pulse_b, exp_pulse[1]);
    chk("held_b",  held_b,  exp_held[1]);
    chk("no_back_to_back", (pulse_a & prev_a) | (pulse_b & prev_b), 0);
    prev_a = pulse_a; prev_b = pulse_b;
    if (idx < 64) begin
      pm_a |= 64'(pulse_a) << idx;
      pm_b |= 64'(pulse_b) << idx;
      hm_a |= 64'(held_a) << idx;
    end
    idx++;
  endtask

  task automatic run(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b1, 1'b0);
  endtask

  initial begin
    model_update();
    prev_a = 0; prev_b = 0;
    begin_test();
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("reset_pulse", {pulse_a, pulse_b}, 2'b00);
    chk("reset_held",  {held_a, held_b}, 2'b00);
    run(1'b0, 4);

    // clean press
    begin_test();
    run(1'b1, 8);
    run(1'b0, 12);
    chk("clean_pulses_a", pm_a, 64'h40);
    chk("clean_pulses_b", pm_b, 64'h40);
    chk("clean_held_a",   hm_a, 64'h3FC0);

    // bounce
    begin_test();
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    run(1'b1, 10);
    run(1'b0, 12);
    chk("bounce_pulses_a", pm_a, 64'h400);
    chk("bounce_pulses_b", pm_b, 64'h400);

    // hold with auto-repeat
    begin_test();
    run(1'b1, 30);
    run(1'b0, 12);
    chk("hold_pulses_a", pm_a, 64'h9249_0040);
    chk("hold_count_a",  $countones(pm_a), 7);
    chk("hold_pulses_b", pm_b, 64'h40);

    // release glitch while held
    begin_test();
    run(1'b1, 12);
    run(1'b0, 2);
    run(1'b1, 14);
    run(1'b0, 10);
    chk("glitch_pulses_a", pm_a, 64'h2400_0040);
    chk("glitch_pulses_b", pm_b, 64'h40);
    chk("glitch_held_a",   hm_a, 64'h3_FFFF_FFC0);

    // en low over the first pulse
    begin_test();
    for (int i = 0; i < 20; i++) step(1'b1, i != 6, 1'b0);
    run(1'b0, 12);
    chk("en_pulses_a", pm_a, 64'h9_0000);
    chk("en_pulses_b", pm_b, 64'h0);

    // asynchronous reset in the middle of a hold, then fresh debounce
    begin_test();
    run(1'b1, 12);
    chk("prereset_pulses_a", pm_a, 64'h40);
    chk("prereset_held_a", held_a, 1'b1);
    @(negedge clk);
    Reset = 1'b1;
    #1;
    chk("async_reset_pulse", {pulse_a, pulse_b}, 2'b00);
    chk("async_reset_held",  {held_a, held_b}, 2'b00);
    @(posedge clk);
    model_update();
    #2;
    chk("reset_hold_held_a", held_a, exp_held[0]);
    prev_a = pulse_a; prev_b = pulse_b;
    begin_test();
    run(1'b1, 10);
    chk("redebounce_pulses_a", pm_a, 64'h40);
    chk("redebounce_pulses_b", pm_b, 64'h40);
    run(1'b0, 12);

    // long hold: repeat disabled on instance b
    begin_test();
    run(1'b1, 50);
    run(1'b0, 12);
    chk("norepeat_pulses_b", pm_b, 64'h40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
